ip_codma_bus_arbiter: RTL and testbench

Shares the single codma memory-bus master port between independent requesters: read machine, write machine, and status write-back from the main machine.
- Round-robin arbitration; the winner's address, size and direction are latched.
- Drives the bus request phase and holds ownership until the bus signals the last beat.
- Sits between the requesting state machines and the top-level bus drive logic; it becomes the single source of bus_read/bus_write/addr/size.

---
 rtl/ip_codma_pkg.sv | 21 ++
 rtl/ip_codma_rr_picker.sv | 34 +++
 rtl/ip_codma_bus_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_ip_codma_bus_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_codma_pkg.sv
// ip_codma_pkg: shared types and constants for the codma bus arbiter slice.
//   arb_state_t    : arbiter FSM states
//   ARB_IDLE_SIZE  : size code driven on the bus when nobody owns it
//   REQ_RD/WR/STAT : requester index assignment on the arbiter ports
package ip_codma_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE    = 3'd0,
    ARB_ASK     = 3'd1,
    ARB_OWNED   = 3'd2,
    ARB_RELEASE = 3'd3,
    ARB_TIMEOUT = 3'd4
  } arb_state_t;

  localparam logic [7:0] ARB_IDLE_SIZE = 8'd9;

  localparam int unsigned REQ_RD   = 0;
  localparam int unsigned REQ_WR   = 1;
  localparam int unsigned REQ_STAT = 2;

endpackage

// File: rtl/ip_codma_rr_picker.sv
// ip_codma_rr_picker: combinational round-robin selector.
//   req_i    : per-requester request vector
//   last_i   : index of the previous owner; the scan starts just above it
//   winner_o : index of the first set request found, scanning upward with wrap
//   valid_o  : at least one request is set
module ip_codma_rr_picker
  import ip_codma_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [IDX_W-1:0]   winner_o,
  output logic               valid_o
);

  logic [IDX_W-1:0] idx;

  // Visit last+1 .. last+NUM_REQ (mod NUM_REQ); the previous owner is checked last.
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    idx      = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = IDX_W'((32'(last_i) + i) % NUM_REQ);
      if (!valid_o && req_i[idx]) begin
        valid_o  = 1'b1;
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/ip_codma_bus_arbiter.sv
// ip_codma_bus_arbiter: shares the codma memory-bus master port between the read
// machine, write machine and status write-back using round-robin arbitration.
//   clk_i, reset_n_i         : clock, asynchronous active-low reset
//   req_i / req_write_i      : per-requester request level and direction (1=write)
//   req_addr_i / req_size_i  : packed per-requester address and size
//   abort_i                  : suppresses new grants (does not cut an owned burst)
//   bus_gnt_i / bus_done_i   : bus accepted request / last beat of transfer
//   gnt_o                    : one-hot ownership to the winning requester
//   bus_read_o / bus_write_o : request phase to the bus
//   bus_addr_o / bus_size_o  : latched address/size of the owner
//   owner_o                  : current or last owner index (round-robin pointer)
//   busy_o                   : arbiter not idle
//   timeout_o                : one-cycle pulse when a stalled ASK/OWNED is aborted
// All outputs are registered.
module ip_codma_bus_arbiter
  import ip_codma_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned SIZE_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic [NUM_REQ-1:0]          req_write_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_REQ*SIZE_W-1:0]   req_size_i,
  input  logic                        abort_i,
  input  logic                        bus_gnt_i,
  input  logic                        bus_done_i,
  output logic [NUM_REQ-1:0]          gnt_o,
  output logic                        bus_read_o,
  output logic                        bus_write_o,
  output logic [ADDR_W-1:0]           bus_addr_o,
  output logic [SIZE_W-1:0]           bus_size_o,
  output logic [$clog2(NUM_REQ)-1:0]  owner_o,
  output logic                        busy_o,
  output logic                        timeout_o
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0]   CntLast  = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [SIZE_W-1:0] IdleSize = SIZE_W'(ARB_IDLE_SIZE);
  localparam logic [IdxW-1:0]   OwnerRst = IdxW'(NUM_REQ - 1);

  arb_state_t          state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic [IdxW-1:0]     owner_q, owner_d;
  logic                busy_q, busy_d;
  logic                timeout_q, timeout_d;

  logic [IdxW-1:0]     pick_idx;
  logic                pick_valid;
  logic [NUM_REQ-1:0]  owner_onehot;
  logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
  logic [SIZE_W-1:0]   size_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : gen_unpack
    assign addr_arr[g] = req_addr_i[g*ADDR_W +: ADDR_W];
    assign size_arr[g] = req_size_i[g*SIZE_W +: SIZE_W];
  end

  ip_codma_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IdxW)
  ) u_picker (
    .req_i    (req_i),
    .last_i   (owner_q),
    .winner_o (pick_idx),
    .valid_o  (pick_valid)
  );

  assign owner_onehot = NUM_REQ'(1) << owner_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;  // restarts on every state change
    gnt_d     = gnt_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    size_d    = size_q;
    owner_d   = owner_q;
    timeout_d = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (pick_valid && !abort_i) begin
          state_d = ARB_ASK;
          owner_d = pick_idx;
          addr_d  = addr_arr[pick_idx];
          size_d  = size_arr[pick_idx];
          rd_d    = !req_write_i[pick_idx];
          wr_d    = req_write_i[pick_idx];
        end
      end

      ARB_ASK: begin
        // Once the bus has accepted, the transfer is committed even if the requester
        // withdrew or abort rose in the same cycle; bus_done_i is ignored here.
        if (bus_gnt_i) begin
          state_d = ARB_OWNED;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          gnt_d   = owner_onehot;
        end else if (!req_i[owner_q] || abort_i) begin
          state_d = ARB_IDLE;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          size_d  = IdleSize;
        end else if (cnt_q == CntLast) begin
          state_d   = ARB_TIMEOUT;
          rd_d      = 1'b0;
          wr_d      = 1'b0;
          size_d    = IdleSize;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ARB_OWNED: begin
        // abort_i and req_i are deliberately not looked at: a burst always completes.
        if (bus_done_i) begin
          state_d = ARB_RELEASE;
          gnt_d   = '0;
          size_d  = IdleSize;
        end else if (cnt_q == CntLast) begin
          state_d   = ARB_TIMEOUT;
          gnt_d     = '0;
          size_d    = IdleSize;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ARB_RELEASE: state_d = ARB_IDLE;

      ARB_TIMEOUT: state_d = ARB_IDLE;

      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        addr_d  = '0;
        size_d  = IdleSize;
      end
    endcase

    busy_d = (state_d != ARB_IDLE);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= ARB_IDLE;
      cnt_q     <= '0;
      gnt_q     <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      size_q    <= IdleSize;
      owner_q   <= OwnerRst;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign bus_read_o  = rd_q;
  assign bus_write_o = wr_q;
  assign bus_addr_o  = addr_q;
  assign bus_size_o  = size_q;
  assign owner_o     = owner_q;
  assign busy_o      = busy_q;
  assign timeout_o   = timeout_q;

  a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (!reset_n_i)
    $onehot0(gnt_q));
  a_rd_wr_excl : assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(rd_q && wr_q));
  a_gnt_owned : assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (gnt_q != '0) |-> (state_q == ARB_OWNED));

endmodule

// File: tb/tb_ip_codma_bus_arbiter.sv
module tb_ip_codma_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  req;
  logic [2:0]  req_write;
  logic [31:0] addr0, addr1, addr2;
  logic [7:0]  size0, size1, size2;
  logic [95:0] req_addr;
  logic [23:0] req_size;
  logic        abort;
  logic        bus_gnt;
  logic        bus_done;
  logic [2:0]  gnt;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_addr;
  logic [7:0]  bus_size;
  logic [1:0]  owner;
  logic        busy;
  logic        timeout;

  int checks   = 0;
  int failures = 0;

  assign req_addr = {addr2, addr1, addr0};
  assign req_size = {size2, size1, size0};

  always #5 clk = ~clk;

  ip_codma_bus_arbiter #(
    .NUM_REQ        (3),
    .ADDR_W         (32),
    .SIZE_W         (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .req_i       (req),
    .req_write_i (req_write),
    .req_addr_i  (req_addr),
    .req_size_i  (req_size),
    .abort_i     (abort),
    .bus_gnt_i   (bus_gnt),
    .bus_done_i  (bus_done),
    .gnt_o       (gnt),
    .bus_read_o  (bus_read),
    .bus_write_o (bus_write),
    .bus_addr_o  (bus_addr),
    .bus_size_o  (bus_size),
    .owner_o     (owner),
    .busy_o      (busy),
    .timeout_o   (timeout)
  );

  typedef struct {
    logic [2:0]  req;
    logic        gnt_in;
    logic        done_in;
    logic [2:0]  e_gnt;
    logic        e_rd;
    logic        e_wr;
    logic [7:0]  e_size;
    logic        e_busy;
    logic [1:0]  e_owner;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  task automatic run_xfer(input logic [1:0] exp_owner, input int n);
    logic       seen;
    logic [2:0] eg;
    seen = 1'b0;
    eg   = 3'b001 << exp_owner;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (bus_read || bus_write) seen = 1'b1;
    end
    check($sformatf("rr%0d.req_seen", n), 32'(seen), 32'd1);
    check($sformatf("rr%0d.owner", n), 32'(owner), 32'(exp_owner));
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    check($sformatf("rr%0d.gnt", n), 32'(gnt), 32'(eg));
    bus_done = 1'b1;
    step();
    bus_done = 1'b0;
    check($sformatf("rr%0d.release_gnt", n), 32'(gnt), 32'd0);
    step();
    check($sformatf("rr%0d.idle_busy", n), 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    // requester 0: read; 1: write; 2: read
    req_write = 3'b010;
    addr0 = 32'h1000; size0 = 8'd4;
    addr1 = 32'h2000; size1 = 8'd8;
    addr2 = 32'h3000; size2 = 8'd12;
    req = 3'b000; abort = 1'b0; bus_gnt = 1'b0; bus_done = 1'b0;
    reset_n = 1'b0;

    // Single read transfer, turnaround, then a withdrawn write request.
    // gnt and done arrive together in ASK (vec 2): only the grant counts.
    vecs[0] = '{req:3'b001, gnt_in:0, done_in:0, e_gnt:3'b000, e_rd:1, e_wr:0,
                e_size:8'd4, e_busy:1, e_owner:2'd0, e_addr:32'h1000};
    vecs[1] = '{req:3'b001, gnt_in:0, done_in:0, e_gnt:3'b000, e_rd:1, e_wr:0,
                e_size:8'd4, e_busy:1, e_owner:2'd0, e_addr:32'h1000};
    vecs[2] = '{req:3'b001, gnt_in:1, done_in:1, e_gnt:3'b001, e_rd:0, e_wr:0,
                e_size:8'd4, e_busy:1, e_owner:2'd0, e_addr:32'h1000};
    vecs[3] = '{req:3'b000, gnt_in:0, done_in:0, e_gnt:3'b001, e_rd:0, e_wr:0,
                e_size:8'd4, e_busy:1, e_owner:2'd0, e_addr:32'h1000};
    vecs[4] = '{req:3'b000, gnt_in:0, done_in:0, e_gnt:3'b001, e_rd:0, e_wr:0,
                e_size:8'd4, e_busy:1, e_owner:2'd0, e_addr:32'h1000};
    vecs[5] = '{req:3'b000, gnt_in:1, done_in:0, e_gnt:3'b001, e_rd:0, e_wr:0,
                e_size:8'd4, e_busy:1, e_owner:2'd0, e_addr:32'h1000};
    vecs[6] = '{req:3'b000, gnt_in:0, done_in:1, e_gnt:3'b000, e_rd:0, e_wr:0,
                e_size:8'd9, e_busy:1, e_owner:2'd0, e_addr:32'h1000};
    vecs[7] = '{req:3'b010, gnt_in:0, done_in:0, e_gnt:3'b000, e_rd:0, e_wr:0,
                e_size:8'd9, e_busy:0, e_owner:2'd0, e_addr:32'h1000};
    vecs[8] = '{req:3'b010, gnt_in:0, done_in:0, e_gnt:3'b000, e_rd:0, e_wr:1,
                e_size:8'd8, e_busy:1, e_owner:2'd1, e_addr:32'h2000};
    vecs[9] = '{req:3'b000, gnt_in:0, done_in:0, e_gnt:3'b000, e_rd:0, e_wr:0,
                e_size:8'd9, e_busy:0, e_owner:2'd1, e_addr:32'h2000};

    // Reset state.
    #12;
    check("rst.gnt", 32'(gnt), 32'd0);
    check("rst.rd", 32'(bus_read), 32'd0);
    check("rst.wr", 32'(bus_write), 32'd0);
    check("rst.addr", bus_addr, 32'd0);
    check("rst.size", 32'(bus_size), 32'd9);
    check("rst.owner", 32'(owner), 32'd2);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.timeout", 32'(timeout), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      req      = vecs[i].req;
      bus_gnt  = vecs[i].gnt_in;
      bus_done = vecs[i].done_in;
      step();
      check($sformatf("vec%0d.gnt", i), 32'(gnt), 32'(vecs[i].e_gnt));
      check($sformatf("vec%0d.rd", i), 32'(bus_read), 32'(vecs[i].e_rd));
      check($sformatf("vec%0d.wr", i), 32'(bus_write), 32'(vecs[i].e_wr));
      check($sformatf("vec%0d.size", i), 32'(bus_size), 32'(vecs[i].e_size));
      check($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].e_busy));
      check($sformatf("vec%0d.owner", i), 32'(owner), 32'(vecs[i].e_owner));
      check($sformatf("vec%0d.addr", i), bus_addr, vecs[i].e_addr);
    end
    bus_gnt = 1'b0;
    bus_done = 1'b0;

    // Round robin with all three requesting: 0,1,2 then 0.
    do_reset();
    req = 3'b111;
    for (int k = 0; k < 4; k++) run_xfer(2'(k % 3), k);
    req = 3'b000;

    // Write requester: latched addr/size survive input changes while owned.
    step();
    req = 3'b010;
    step();
    check("wr.write", 32'(bus_write), 32'd1);
    check("wr.read", 32'(bus_read), 32'd0);
    check("wr.addr", bus_addr, 32'h2000);
    check("wr.size", 32'(bus_size), 32'd8);
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    req = 3'b000;
    addr1 = 32'hDEAD_0000;
    size1 = 8'h55;
    step();
    step();
    check("wr.owned_gnt", 32'(gnt), 32'b010);
    check("wr.owned_addr", bus_addr, 32'h2000);
    check("wr.owned_size", 32'(bus_size), 32'd8);
    bus_done = 1'b1;
    step();
    bus_done = 1'b0;
    step();
    addr1 = 32'h2000;
    size1 = 8'd8;

    // Timeout: grant never arrives, pulse after 16 ASK cycles.
    req = 3'b010;
    step();
    check("to.ask_wr", 32'(bus_write), 32'd1);
    ok = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      if (timeout !== 1'b0 || bus_write !== 1'b1) ok = 1'b0;
    end
    check("to.no_early_pulse", 32'(ok), 32'd1);
    step();
    check("to.pulse", 32'(timeout), 32'd1);
    check("to.wr_cleared", 32'(bus_write), 32'd0);
    check("to.gnt", 32'(gnt), 32'd0);
    step();
    check("to.pulse_end", 32'(timeout), 32'd0);
    check("to.idle", 32'(busy), 32'd0);
    step();
    check("to.rerequest", 32'(bus_write), 32'd1);
    req = 3'b000;
    step();
    check("to.withdrawn", 32'(busy), 32'd0);

    // Abort mid-burst: burst completes, no new grant while abort is high.
    req = 3'b011;
    step();
    check("ab.owner", 32'(owner), 32'd0);
    check("ab.rd", 32'(bus_read), 32'd1);
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    abort = 1'b1;
    step();
    check("ab.owned_gnt", 32'(gnt), 32'b001);
    bus_done = 1'b1;
    step();
    bus_done = 1'b0;
    check("ab.release", 32'(gnt), 32'd0);
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (busy !== 1'b0 || bus_read !== 1'b0 || bus_write !== 1'b0) ok = 1'b0;
    end
    check("ab.held_off", 32'(ok), 32'd1);
    abort = 1'b0;
    step();
    check("ab.resume_owner", 32'(owner), 32'd1);
    check("ab.resume_wr", 32'(bus_write), 32'd1);
    req = 3'b000;
    step();

    // Async reset while owned.
    req = 3'b001;
    step();
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    check("ar.owned_gnt", 32'(gnt), 32'b001);
    reset_n = 1'b0;
    #1;
    check("ar.gnt", 32'(gnt), 32'd0);
    check("ar.size", 32'(bus_size), 32'd9);
    check("ar.owner", 32'(owner), 32'd2);
    check("ar.busy", 32'(busy), 32'd0);
    #1;
    reset_n = 1'b1;
    req = 3'b111;
    step();
    check("ar.next_owner", 32'(owner), 32'd0);
    check("ar.next_rd", 32'(bus_read), 32'd1);
    req = 3'b000;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
